er_rom_loader: RTL and testbench

//  Upstream of the game core: turns the 16-bit ioctl ROM download stream into byte writes for the

---
 rtl/er_rom_loader.sv | 151 +++++++++++++++
 tb/tb_er_rom_loader.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/er_rom_loader.sv
// rtl/er_rom_loader.sv - ioctl ROM download stream to per-region byte writes
// Words are queued in a small FIFO, then written as low byte followed by high byte.
module er_rom_loader #(
  parameter int          DEPTH   = 4,
  parameter logic [7:0]  IDX_ROM = 8'd0,
  parameter logic [26:0] R1_BASE = 27'h10000,
  parameter logic [26:0] R2_BASE = 27'h18000,
  parameter logic [26:0] R3_BASE = 27'h1C000,
  parameter logic [26:0] R4_BASE = 27'h24000,
  parameter logic [26:0] R5_BASE = 27'h44000,
  parameter logic [26:0] R6_BASE = 27'h74000,
  parameter logic [26:0] R_END   = 27'h74400
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic [26:0] ioctl_addr,
  input  logic [15:0] ioctl_dout,
  input  logic        ioctl_wr,
  output logic        ioctl_wait,
  output logic        rom_we,
  output logic [2:0]  rom_region,
  output logic [17:0] rom_addr,
  output logic [7:0]  rom_data,
  output logic        dl_busy,
  output logic        dl_done,
  output logic [7:0]  checksum,
  output logic        overflow
);

  localparam int             AW       = $clog2(DEPTH);
  localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]    WAIT_CNT = (AW+1)'(DEPTH-1);

  typedef enum logic [1:0] {IDLE, LO, HI} state_t;

  logic [41:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_next;
  state_t        state;
  logic          dl_prev;
  logic [25:0]   cur_waddr;
  logic [7:0]    cur_hi;
  logic          dl_act, accept, full, push, pop, start, drained;
  logic [41:0]   head;
  logic [21:0]   lo_dec, hi_dec;
  logic          unused_addr0;

  // Returns {in_range, region, offset}; region is the highest base not above the address.
  function automatic logic [21:0] decode(input logic [26:0] a);
    logic [2:0]  r;
    logic [17:0] base;
    r = 3'd0;
    base = 18'd0;
    if (a >= R1_BASE) begin r = 3'd1; base = R1_BASE[17:0]; end
    if (a >= R2_BASE) begin r = 3'd2; base = R2_BASE[17:0]; end
    if (a >= R3_BASE) begin r = 3'd3; base = R3_BASE[17:0]; end
    if (a >= R4_BASE) begin r = 3'd4; base = R4_BASE[17:0]; end
    if (a >= R5_BASE) begin r = 3'd5; base = R5_BASE[17:0]; end
    if (a >= R6_BASE) begin r = 3'd6; base = R6_BASE[17:0]; end
    return {a < R_END, r, a[17:0] - base};
  endfunction

  assign unused_addr0 = ioctl_addr[0];
  assign dl_act  = ioctl_download && (ioctl_index == IDX_ROM);
  assign accept  = ioctl_wr && dl_act;
  assign full    = (count == FULL_CNT);
  assign push    = accept && !full;
  assign pop     = (state != LO) && (count != '0);
  assign start   = dl_act && !dl_prev;
  assign drained = dl_busy && !dl_act && (count == '0) && (state == IDLE);
  assign head    = mem[rd_ptr];
  assign lo_dec  = decode({head[41:16], 1'b0});
  assign hi_dec  = decode({cur_waddr, 1'b1});

  always_comb begin
    count_next = count;
    if (push && !pop)
      count_next = count + 1'b1;
    else if (pop && !push)
      count_next = count - 1'b1;
  end

  always_ff @(posedge clk_sys) begin
    if (push)
      mem[wr_ptr] <= {ioctl_addr[26:1], ioctl_dout};
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      state      <= IDLE;
      dl_prev    <= 1'b0;
      cur_waddr  <= '0;
      cur_hi     <= '0;
      ioctl_wait <= 1'b0;
      rom_we     <= 1'b0;
      rom_region <= '0;
      rom_addr   <= '0;
      rom_data   <= '0;
      dl_busy    <= 1'b0;
      dl_done    <= 1'b0;
      checksum   <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count      <= count_next;
      ioctl_wait <= (count_next >= WAIT_CNT);
      dl_prev    <= dl_act;
      dl_done    <= 1'b0;
      rom_we     <= 1'b0;

      if (state == LO) begin
        state      <= HI;
        rom_we     <= hi_dec[21];
        rom_region <= hi_dec[20:18];
        rom_addr   <= hi_dec[17:0];
        rom_data   <= cur_hi;
      end else if (pop) begin
        state      <= LO;
        cur_waddr  <= head[41:16];
        cur_hi     <= head[15:8];
        rom_we     <= lo_dec[21];
        rom_region <= lo_dec[20:18];
        rom_addr   <= lo_dec[17:0];
        rom_data   <= head[7:0];
      end else begin
        state <= IDLE;
      end

      if (start) begin
        checksum <= '0;
        overflow <= 1'b0;
        dl_busy  <= 1'b1;
      end else begin
        if (rom_we) checksum <= checksum + rom_data;
        if (drained) begin
          dl_done <= 1'b1;
          dl_busy <= 1'b0;
        end
      end
      if (accept && full)
        overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_er_rom_loader.sv
// tb/tb_er_rom_loader.sv - randomized self-checking bench for er_rom_loader
// Reference model: FIFO occupancy plus an ordered list of expected byte writes.
module tb_er_rom_loader;

  localparam int          DEPTH = 4;
  localparam logic [26:0] R_END = 27'h74400;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ioctl_download = 1'b0;
  logic [7:0]  ioctl_index = 8'd0;
  logic [26:0] ioctl_addr = '0;
  logic [15:0] ioctl_dout = '0;
  logic        ioctl_wr = 1'b0;
  logic        ioctl_wait, rom_we, dl_busy, dl_done, overflow;
  logic [2:0]  rom_region;
  logic [17:0] rom_addr;
  logic [7:0]  rom_data, checksum;

  er_rom_loader #(.DEPTH(DEPTH)) dut (
    .clk_sys(clk), .reset_n(reset_n), .ioctl_download(ioctl_download),
    .ioctl_index(ioctl_index), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .ioctl_wr(ioctl_wr), .ioctl_wait(ioctl_wait), .rom_we(rom_we),
    .rom_region(rom_region), .rom_addr(rom_addr), .rom_data(rom_data),
    .dl_busy(dl_busy), .dl_done(dl_done), .checksum(checksum), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;
  int done_cnt = 0, wr_cnt = 0;

  logic [26:0] bases [7] = '{27'h0, 27'h10000, 27'h18000, 27'h1C000,
                             27'h24000, 27'h44000, 27'h74000};
  logic [28:0] expq [$];
  int   q_cnt = 0, ph = 0;
  bit   busy_m = 0, done_m = 0, ovf_m = 0, wait_m = 0, dl_prev_m = 0;
  logic [7:0] ck_m = '0;

  task automatic add_word(input logic [26:0] a, input logic [15:0] d);
    for (int b = 0; b < 2; b++) begin
      logic [26:0] ba, off;
      int k;
      ba = {a[26:1], b[0]};
      if (ba < R_END) begin
        k = 0;
        for (int j = 0; j < 7; j++) if (ba >= bases[j]) k = j;
        off = ba - bases[k];
        expq.push_back({3'(k), off[17:0], (b == 1) ? d[15:8] : d[7:0]});
      end
    end
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_cnt = 0; ph = 0; expq.delete();
      busy_m = 0; done_m = 0; ovf_m = 0; wait_m = 0; dl_prev_m = 0; ck_m = '0;
    end else begin
      bit act, acc, full, popv, drain;
      act   = ioctl_download && (ioctl_index == 8'd0);
      acc   = ioctl_wr && act;
      full  = (q_cnt == DEPTH);
      popv  = (ph != 1) && (q_cnt > 0);
      drain = busy_m && !act && (q_cnt == 0) && (ph == 0);
      done_m = 0;
      if (act && !dl_prev_m) begin
        busy_m = 1; ovf_m = 0; ck_m = '0;
      end else if (drain) begin
        busy_m = 0; done_m = 1;
      end
      if (acc && full) ovf_m = 1;
      if (acc && !full) begin
        q_cnt++;
        add_word(ioctl_addr, ioctl_dout);
      end
      if (popv) q_cnt--;
      ph = popv ? 1 : ((ph == 1) ? 2 : 0);
      wait_m = (q_cnt >= DEPTH - 1);
      dl_prev_m = act;
    end
  end

  always @(negedge clk) begin
    vectors++;
    if (checksum !== ck_m) begin
      miscompares++;
      $display("FAIL checksum got=%h exp=%h t=%0t", checksum, ck_m, $time);
    end
    vectors++;
    if ({ioctl_wait, overflow, dl_busy, dl_done} !== {wait_m, ovf_m, busy_m, done_m}) begin
      miscompares++;
      $display("FAIL ctrl {wait,ovf,busy,done} got=%b exp=%b t=%0t",
               {ioctl_wait, overflow, dl_busy, dl_done}, {wait_m, ovf_m, busy_m, done_m}, $time);
    end
    if (rom_we !== 1'b0) begin
      vectors++;
      wr_cnt++;
      if (expq.size() == 0) begin
        miscompares++;
        $display("FAIL spurious_write got region=%0d addr=%h data=%h exp none t=%0t",
                 rom_region, rom_addr, rom_data, $time);
      end else begin
        logic [28:0] e;
        e = expq.pop_front();
        if ({rom_region, rom_addr, rom_data} !== e) begin
          miscompares++;
          $display("FAIL write got=%h/%h/%h exp=%h/%h/%h t=%0t", rom_region, rom_addr, rom_data,
                   e[28:26], e[25:8], e[7:0], $time);
        end
        ck_m = ck_m + e[7:0];
      end
    end
    if (dl_done === 1'b1) done_cnt++;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic [26:0] a, input logic [15:0] d);
    ioctl_addr = a; ioctl_dout = d; ioctl_wr = 1'b1;
    step();
    ioctl_wr = 1'b0;
  endtask

  task automatic start_dl(input logic [7:0] idx);
    ioctl_index = idx; ioctl_download = 1'b1;
    step();
  endtask

  task automatic end_dl();
    int n;
    ioctl_download = 1'b0;
    n = 0;
    while ((dl_busy !== 1'b0 || busy_m) && n < 200) begin step(); n++; end
    vectors++;
    if (n >= 200) begin
      miscompares++;
      $display("FAIL drain_timeout busy=%b exp 0", dl_busy);
    end
    step(); step();
  endtask

  task automatic check_expq_empty(input string name);
    vectors++;
    if (expq.size() != 0) begin
      miscompares++;
      $display("FAIL %s pending_writes got=%0d exp 0", name, expq.size());
    end
  endtask

  task automatic test_reset();
    step(); step();
    vectors++;
    if ({ioctl_wait, rom_we, rom_region, rom_addr, rom_data, dl_busy, dl_done, checksum, overflow} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs got nonzero exp 0");
    end
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    int d0;
    d0 = done_cnt;
    start_dl(8'd0);
    send(27'h0, 16'hA55A);
    vectors++;
    if (rom_we !== 1'b0) begin miscompares++; $display("FAIL basic_early_we got=%b exp 0", rom_we); end
    step();
    vectors++;
    if ({rom_we, rom_region, rom_addr, rom_data} !== {1'b1, 3'd0, 18'd0, 8'h5A}) begin
      miscompares++;
      $display("FAIL basic_lo got we=%b r=%0d a=%h d=%h exp 1/0/0/5a", rom_we, rom_region, rom_addr, rom_data);
    end
    step();
    vectors++;
    if ({rom_we, rom_region, rom_addr, rom_data} !== {1'b1, 3'd0, 18'd1, 8'hA5}) begin
      miscompares++;
      $display("FAIL basic_hi got we=%b r=%0d a=%h d=%h exp 1/0/1/a5", rom_we, rom_region, rom_addr, rom_data);
    end
    end_dl();
    vectors++;
    if (checksum !== 8'hFF) begin miscompares++; $display("FAIL basic_checksum got=%h exp ff", checksum); end
    vectors++;
    if (done_cnt - d0 != 1) begin miscompares++; $display("FAIL basic_done got=%0d exp 1", done_cnt - d0); end
    check_expq_empty("basic");
  endtask

  task automatic test_region1();
    start_dl(8'd0);
    send(27'h10002, 16'h1234);
    step();
    vectors++;
    if ({rom_we, rom_region, rom_addr, rom_data} !== {1'b1, 3'd1, 18'd2, 8'h34}) begin
      miscompares++;
      $display("FAIL region1_lo got we=%b r=%0d a=%h d=%h exp 1/1/2/34", rom_we, rom_region, rom_addr, rom_data);
    end
    step();
    vectors++;
    if ({rom_we, rom_region, rom_addr, rom_data} !== {1'b1, 3'd1, 18'd3, 8'h12}) begin
      miscompares++;
      $display("FAIL region1_hi got we=%b r=%0d a=%h d=%h exp 1/1/3/12", rom_we, rom_region, rom_addr, rom_data);
    end
    end_dl();
    check_expq_empty("region1");
  endtask

  task automatic test_out_of_range();
    int d0, w0;
    d0 = done_cnt; w0 = wr_cnt;
    start_dl(8'd0);
    send(R_END, 16'hBEEF);
    send(27'h743FE, 16'h0102);
    end_dl();
    vectors++;
    if (wr_cnt - w0 != 2) begin miscompares++; $display("FAIL oor_writes got=%0d exp 2", wr_cnt - w0); end
    vectors++;
    if (checksum !== 8'h03) begin miscompares++; $display("FAIL oor_checksum got=%h exp 03", checksum); end
    vectors++;
    if (done_cnt - d0 != 1) begin miscompares++; $display("FAIL oor_done got=%0d exp 1", done_cnt - d0); end
  endtask

  task automatic test_other_index();
    int d0, w0;
    d0 = done_cnt; w0 = wr_cnt;
    start_dl(8'd1);
    for (int i = 0; i < 3; i++) send(27'(i * 2), 16'h1111 * 16'(i + 1));
    vectors++;
    if (dl_busy !== 1'b0) begin miscompares++; $display("FAIL idx1_busy got=%b exp 0", dl_busy); end
    end_dl();
    repeat (4) step();
    vectors++;
    if ((done_cnt - d0) != 0 || (wr_cnt - w0) != 0) begin
      miscompares++;
      $display("FAIL idx1_activity got done=%0d writes=%0d exp 0/0", done_cnt - d0, wr_cnt - w0);
    end
    ioctl_index = 8'd0;
  endtask

  task automatic test_overflow();
    int w0;
    w0 = wr_cnt;
    start_dl(8'd0);
    vectors++;
    if (overflow !== 1'b0) begin miscompares++; $display("FAIL ovf_start got=%b exp 0", overflow); end
    for (int i = 0; i < 12; i++) send(27'h18000 + 27'(i * 2), 16'($urandom));
    vectors++;
    if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_sticky got=%b exp 1", overflow); end
    end_dl();
    vectors++;
    if (wr_cnt - w0 >= 24) begin miscompares++; $display("FAIL ovf_dropped got writes=%0d exp <24", wr_cnt - w0); end
    check_expq_empty("overflow");
  endtask

  task automatic test_back_to_back_random();
    for (int dl = 0; dl < 3; dl++) begin
      int d0;
      d0 = done_cnt;
      start_dl(8'd0);
      for (int i = 0; i < 24; i++) begin
        int k, n;
        logic [26:0] a;
        repeat ($urandom_range(0, 2)) step();
        n = 0;
        while (ioctl_wait === 1'b1 && n < 50) begin step(); n++; end
        k = $urandom_range(0, 7);
        a = (k == 7) ? R_END : bases[k];
        if ($urandom_range(0, 3) == 0 && k != 0) a = a - 27'd2;
        else a = a + 27'($urandom_range(0, 511) * 2);
        send(a, 16'($urandom));
      end
      end_dl();
      vectors++;
      if (overflow !== 1'b0) begin miscompares++; $display("FAIL rand_ovf got=%b exp 0", overflow); end
      vectors++;
      if (done_cnt - d0 != 1) begin miscompares++; $display("FAIL rand_done got=%0d exp 1", done_cnt - d0); end
      check_expq_empty("random");
    end
  endtask

  task automatic test_empty_download();
    int d0, w0;
    d0 = done_cnt; w0 = wr_cnt;
    start_dl(8'd0);
    step();
    end_dl();
    vectors++;
    if ((done_cnt - d0) != 1 || (wr_cnt - w0) != 0) begin
      miscompares++;
      $display("FAIL empty_dl got done=%0d writes=%0d exp 1/0", done_cnt - d0, wr_cnt - w0);
    end
  endtask

  task automatic test_reset_mid();
    int w0;
    start_dl(8'd0);
    send(27'h24000, 16'hCAFE);
    send(27'h24002, 16'hBABE);
    send(27'h24004, 16'hF00D);
    reset_n = 1'b0;
    #1;
    vectors++;
    if ({ioctl_wait, rom_we, rom_region, rom_addr, rom_data, dl_busy, dl_done, checksum, overflow} !== '0) begin
      miscompares++;
      $display("FAIL reset_mid_outputs got nonzero exp 0");
    end
    ioctl_download = 1'b0;
    step(); step();
    reset_n = 1'b1;
    w0 = wr_cnt;
    repeat (10) step();
    vectors++;
    if (wr_cnt - w0 != 0) begin miscompares++; $display("FAIL reset_mid_writes got=%0d exp 0", wr_cnt - w0); end
    check_expq_empty("reset_mid");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_region1();
    test_out_of_range();
    test_other_index();
    test_overflow();
    test_back_to_back_random();
    test_empty_download();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
